// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and receiver FSM states.
// Used by both the receive and transmit blocks.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// RST_VAL sets the value both flops take during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional parity, 1-2 stop bits.
// Samples mid-bit, reports parity and framing errors alongside each word.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 100,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_line,
    output logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);
    localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);

    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] sr;
    logic                 perr;
    logic                 ferr;
    logic                 rx_s;
    logic                 stop_low;
    logic                 tick;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_line),
        .q   (rx_s)
    );

    assign tick     = (cnt == '0);
    assign stop_low = ferr | ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sr         <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            ready      <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= HALF;
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= FULL;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        sr  <= {rx_s, sr[DATA_BITS-1:1]};
                        cnt <= FULL;
                        if (idx == LAST_D) begin
                            idx   <= '0;
                            perr  <= 1'b0;
                            ferr  <= 1'b0;
                            state <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Total XOR of data plus parity bit is 1 for odd, 0 for even
                        perr  <= (^sr ^ rx_s) != (PARITY == PAR_ODD);
                        cnt   <= FULL;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt  <= FULL;
                        ferr <= stop_low;
                        if (idx == LAST_S) begin
                            idx        <= '0;
                            ready      <= 1'b1;
                            data       <= sr;
                            parity_err <= (PARITY != PAR_NONE) && perr;
                            frame_err  <= stop_low;
                            if (stop_low) begin
                                state <= BRK;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised frame bench for uart_rx_cfg: an 8E1 and a 7N2 receiver
// checked against an expected-word queue built from the frames sent.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int  CPB = 32;
    localparam real BT  = 320.0;
    localparam real BTF = 310.0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic       ready_a, perr_a, ferr_a, busy_a;
    logic       ready_b, perr_b, ferr_b, busy_b;
    logic [7:0] data_a;
    logic [6:0] data_b;

    // expected entry layout: {frame_err, parity_err, data[8:0]}
    logic [10:0] qa[$];
    logic [10:0] qb[$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .CLK_PER_BIT (CPB),
        .DATA_BITS   (8),
        .PARITY      (2),
        .STOP_BITS   (1)
    ) u_a (
        .clk         (clk),
        .rst         (rst),
        .serial_line (line_a),
        .ready       (ready_a),
        .data        (data_a),
        .parity_err  (perr_a),
        .frame_err   (ferr_a),
        .busy        (busy_a)
    );

    uart_rx_cfg #(
        .CLK_PER_BIT (CPB),
        .DATA_BITS   (7),
        .PARITY      (0),
        .STOP_BITS   (2)
    ) u_b (
        .clk         (clk),
        .rst         (rst),
        .serial_line (line_b),
        .ready       (ready_b),
        .data        (data_b),
        .parity_err  (perr_b),
        .frame_err   (ferr_b),
        .busy        (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // even parity: an odd number of ones over data plus parity bit is an error
    function automatic logic even_err(input logic [8:0] w, input int nb,
                                      input logic pb);
        int ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(w[i]);
        return ((ones + int'(pb)) % 2) != 0;
    endfunction

    task automatic drive(input bit sel, input logic v);
        if (sel) line_b = v;
        else line_a = v;
    endtask

    // pb < 0 means no parity bit on the wire
    task automatic send(input bit sel, input logic [8:0] w, input int nb,
                        input int pb, input int nstop, input logic stop_v,
                        input real bt);
        drive(sel, 1'b0);
        #(bt);
        for (int i = 0; i < nb; i++) begin
            drive(sel, w[i]);
            #(bt);
        end
        if (pb >= 0) begin
            drive(sel, pb[0]);
            #(bt);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(sel, stop_v);
            #(bt);
        end
        drive(sel, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst && ready_a) begin
            if (qa.size() == 0) begin
                check("a_spurious_ready", 32'd1, 32'd0);
            end else begin
                check("a_data", 32'(data_a), 32'(qa[0][7:0]));
                check("a_parity_err", 32'(perr_a), 32'(qa[0][9]));
                check("a_frame_err", 32'(ferr_a), 32'(qa[0][10]));
                void'(qa.pop_front());
            end
        end
        if (!rst && ready_b) begin
            if (qb.size() == 0) begin
                check("b_spurious_ready", 32'd1, 32'd0);
            end else begin
                check("b_data", 32'(data_b), 32'(qb[0][6:0]));
                check("b_parity_err", 32'(perr_b), 32'(qb[0][9]));
                check("b_frame_err", 32'(ferr_b), 32'(qb[0][10]));
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] w;
        logic       pb;
        int         waited;

        // reset state
        #20;
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_data_a", 32'(data_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_errs_a", 32'({perr_a, ferr_a}), 32'd0);
        check("rst_data_b", 32'(data_b), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        #3 rst = 1'b0;
        #(BT * 2);

        // random 8E1 frames with 1-bit idle gaps, some with bad parity
        for (int k = 0; k < 40; k++) begin
            w  = 9'($urandom_range(0, 255));
            pb = ^w[7:0] ^ ($urandom_range(0, 3) == 0);
            qa.push_back({1'b0, even_err(w, 8, pb), w});
            send(1'b0, w, 8, int'(pb), 1, 1'b1, BT);
            #(BT);
        end

        // even parity on 0xA5: parity 0 is correct, parity 1 is wrong
        qa.push_back({1'b0, 1'b0, 9'h0A5});
        send(1'b0, 9'h0A5, 8, 0, 1, 1'b1, BT);
        #(BT);
        qa.push_back({1'b0, 1'b1, 9'h0A5});
        send(1'b0, 9'h0A5, 8, 1, 1, 1'b1, BT);
        #(BT);
        check("par_err_held", 32'(perr_a), 32'd1);

        // false start: short low pulse must not produce a frame
        line_a = 1'b0;
        #(60);
        check("fs_busy_high", 32'(busy_a), 32'd1);
        #(40);
        line_a = 1'b1;
        waited = 0;
        while (busy_a && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("fs_busy_clear", 32'(busy_a), 32'd0);
        #(BT * 2);

        // break: 0x00 with stop held low for 3 bit times, then 0x3C
        qa.push_back({1'b1, 1'b0, 9'h000});
        fork
            send(1'b0, 9'h000, 8, 0, 3, 1'b0, BT);
            begin
                #(BT * 11.5);
                check("brk_busy_held", 32'(busy_a), 32'd1);
                check("brk_frame_err", 32'(ferr_a), 32'd1);
            end
        join
        #(BT * 2);
        check("brk_busy_clear", 32'(busy_a), 32'd0);
        qa.push_back({1'b0, 1'b0, 9'h03C});
        send(1'b0, 9'h03C, 8, 0, 1, 1'b1, BT);
        #(BT);
        check("post_brk_ferr", 32'(ferr_a), 32'd0);

        // 7N2 back-to-back frames from a ~3% fast sender
        for (int k = 0; k < 20; k++) begin
            w = 9'($urandom_range(0, 127));
            qb.push_back({1'b0, 1'b0, w});
            send(1'b1, w, 7, -1, 2, 1'b1, BTF);
        end
        #(BT * 2);

        // reset during bit 4 of a frame aborts it
        qa.push_back({1'b0, 1'b0, 9'h0C3});
        send(1'b0, 9'h0C3, 8, 0, 1, 1'b1, BT);
        #(BT);
        fork
            send(1'b0, 9'h012, 8, 0, 1, 1'b1, BT);
            begin
                #(BT * 5.5);
                check("pre_rst_busy", 32'(busy_a), 32'd1);
                rst = 1'b1;
                #(20);
                check("in_rst_data", 32'(data_a), 32'd0);
                check("in_rst_busy", 32'(busy_a), 32'd0);
                check("in_rst_ready", 32'(ready_a), 32'd0);
                check("in_rst_errs", 32'({perr_a, ferr_a}), 32'd0);
            end
        join
        #(BT);
        rst = 1'b0;
        #(BT);
        qa.push_back({1'b0, 1'b0, 9'h05A});
        send(1'b0, 9'h05A, 8, 0, 1, 1'b1, BT);
        #(BT * 2);

        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
